// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 memory slave in front of a single-port inferred SRAM.
// Handles one transaction at a time: FIXED/INCR/WRAP bursts, byte strobes,
// ID reflection and round-robin arbitration between AW and AR.
// Optional build macro AXI_SRAM_OOR_SLVERR_EN: out-of-range beats are
// suppressed and answered with SLVERR instead of wrapping around the array.
`timescale 1ns/1ps

package axi_sram_pkg;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int AXI_USER_WIDTH = 1;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]     awid;
      logic [AXI_ADDR_WIDTH-1:0]   awaddr;
      logic [7:0]                  awlen;
      logic [2:0]                  awsize;
      logic [1:0]                  awburst;
      logic                        awvalid;
      logic [AXI_DATA_WIDTH-1:0]   wdata;
      logic [AXI_DATA_WIDTH/8-1:0] wstrb;
      logic                        wlast;
      logic                        wvalid;
      logic                        bready;
      logic [AXI_ID_WIDTH-1:0]     arid;
      logic [AXI_ADDR_WIDTH-1:0]   araddr;
      logic [7:0]                  arlen;
      logic [2:0]                  arsize;
      logic [1:0]                  arburst;
      logic                        arvalid;
      logic                        rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic                        awready;
      logic                        wready;
      logic [AXI_ID_WIDTH-1:0]     bid;
      logic [1:0]                  bresp;
      logic [AXI_USER_WIDTH-1:0]   buser;
      logic                        bvalid;
      logic                        arready;
      logic [AXI_ID_WIDTH-1:0]     rid;
      logic [AXI_DATA_WIDTH-1:0]   rdata;
      logic [1:0]                  rresp;
      logic                        rlast;
      logic                        rvalid;
   } s_axi_miso_t;
endpackage

module axi_sram_slave
   import axi_sram_pkg::*;
#(
   parameter int          MEM_KB    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter              INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        arst,
   input  s_axi_mosi_t axi_mosi,
   output s_axi_miso_t axi_miso
);
   localparam int          STRB_W      = AXI_DATA_WIDTH/8;
   localparam int          WORDS       = MEM_KB*1024/STRB_W;
   localparam int          IDX_W       = $clog2(WORDS);
   localparam int          OFF_LSB     = $clog2(STRB_W);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

   state_t                    state_reg, state_next;
   logic                      prio_reg;          // 0: write wins a tie, 1: read wins
   logic [AXI_ID_WIDTH-1:0]   id_reg;
   logic [31:0]               addr_reg;          // address of the beat in flight
   logic [7:0]                len_reg;
   logic [2:0]                size_reg;
   logic [1:0]                burst_reg;
   logic [7:0]                beat_reg;
   logic                      berr_reg;
   logic [AXI_DATA_WIDTH-1:0] rdata_reg;
   logic                      rerr_reg;

   logic [AXI_DATA_WIDTH-1:0] mem [WORDS];

   logic        aw_hs, ar_hs, w_hs, b_hs, r_hs;
   logic        last_beat, rd_en, wr_en, wr_ok, rd_ok;
   logic [31:0] addr_next, rd_addr;
   logic        unused_wlast;

   // Burst termination is by beat count; wlast carries no extra information.
   assign unused_wlast = axi_mosi.wlast;

   function automatic logic [31:0] burst_next(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
      logic [31:0] bytes;
      logic [31:0] mask;
      logic [31:0] result;
      bytes = 32'd1 << size;
      mask  = (bytes * (32'(len) + 32'd1)) - 32'd1;
      if (burst == BURST_FIXED)
         result = addr;
      else if (burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         result = (addr & ~mask) | ((addr + bytes) & mask);
      else
         result = addr + bytes;   // INCR, reserved burst type and illegal WRAP lengths
      return result;
   endfunction

   // Word index wraps modulo the array; low byte-lane bits are dropped.
   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> OFF_LSB);
   endfunction

`ifdef AXI_SRAM_OOR_SLVERR_EN
   function automatic logic in_range(input logic [31:0] addr);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, BASE_ADDR};
      return !off[32] && (off[31:0] < 32'(MEM_KB*1024));
   endfunction
   assign wr_ok = in_range(addr_reg);
   assign rd_ok = in_range(rd_addr);
`else
   assign wr_ok = 1'b1;
   assign rd_ok = 1'b1;
`endif

   assign last_beat = (beat_reg == len_reg);
   assign addr_next = burst_next(addr_reg, size_reg, len_reg, burst_reg);
   // Reads are issued on the AR handshake and on every non-final R handshake.
   assign rd_addr   = ar_hs ? axi_mosi.araddr : addr_next;
   assign rd_en     = ar_hs || (r_hs && !last_beat);
   assign wr_en     = w_hs && wr_ok;

   // Next-state decode and channel handshakes; readies are held low during reset.
   always_comb begin
      state_next = state_reg;
      aw_hs      = 1'b0;
      ar_hs      = 1'b0;
      w_hs       = 1'b0;
      b_hs       = 1'b0;
      r_hs       = 1'b0;
      case (state_reg)
         IDLE: begin
            aw_hs = arst && axi_mosi.awvalid && (!axi_mosi.arvalid || !prio_reg);
            ar_hs = arst && axi_mosi.arvalid && !aw_hs;
            if (aw_hs)
               state_next = WR_DATA;
            else if (ar_hs)
               state_next = RD_DATA;
         end
         WR_DATA: begin
            w_hs = axi_mosi.wvalid;
            if (w_hs && last_beat)
               state_next = WR_RESP;
         end
         WR_RESP: begin
            b_hs = axi_mosi.bready;
            if (b_hs)
               state_next = IDLE;
         end
         RD_DATA: begin
            r_hs = axi_mosi.rready;
            if (r_hs && last_beat)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Latched burst context, beat counter, arbitration priority and write error flag.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         prio_reg  <= 1'b0;
         id_reg    <= '0;
         addr_reg  <= '0;
         len_reg   <= '0;
         size_reg  <= '0;
         burst_reg <= '0;
         beat_reg  <= '0;
         berr_reg  <= 1'b0;
      end else if (aw_hs || ar_hs) begin
         prio_reg  <= ~prio_reg;
         id_reg    <= aw_hs ? axi_mosi.awid    : axi_mosi.arid;
         addr_reg  <= aw_hs ? axi_mosi.awaddr  : axi_mosi.araddr;
         len_reg   <= aw_hs ? axi_mosi.awlen   : axi_mosi.arlen;
         size_reg  <= aw_hs ? axi_mosi.awsize  : axi_mosi.arsize;
         burst_reg <= aw_hs ? axi_mosi.awburst : axi_mosi.arburst;
         beat_reg  <= '0;
         berr_reg  <= 1'b0;
      end else if (w_hs || r_hs) begin
         addr_reg <= addr_next;
         beat_reg <= beat_reg + 8'd1;
         if (w_hs && !wr_ok)
            berr_reg <= 1'b1;
      end
   end

   // SRAM write port with byte enables.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi_mosi.wstrb[b])
               mem[word_idx(addr_reg)][b*8 +: 8] <= axi_mosi.wdata[b*8 +: 8];
         end
      end
   end

   // Registered SRAM read; data holds whenever no read is issued (rready low).
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         rdata_reg <= '0;
         rerr_reg  <= 1'b0;
      end else if (rd_en) begin
         rdata_reg <= rd_ok ? mem[word_idx(rd_addr)] : '0;
         rerr_reg  <= !rd_ok;
      end
   end

   assign axi_miso.awready = aw_hs;
   assign axi_miso.wready  = (state_reg == WR_DATA);
   assign axi_miso.bid     = id_reg;
   assign axi_miso.bresp   = berr_reg ? RESP_SLVERR : RESP_OKAY;
   assign axi_miso.buser   = '0;
   assign axi_miso.bvalid  = (state_reg == WR_RESP);
   assign axi_miso.arready = ar_hs;
   assign axi_miso.rid     = id_reg;
   assign axi_miso.rdata   = rdata_reg;
   assign axi_miso.rresp   = rerr_reg ? RESP_SLVERR : RESP_OKAY;
   assign axi_miso.rlast   = (state_reg == RD_DATA) && last_beat;
   assign axi_miso.rvalid  = (state_reg == RD_DATA);
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed self-checking bench for axi_sram_slave.
// Expected read beats are queued when a read is issued and popped as R beats arrive.
// Build with AXI_SRAM_OOR_SLVERR_EN defined to exercise the out-of-range responses.
`timescale 1ns/1ps

module tb_axi_sram_slave;
   import axi_sram_pkg::*;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] WRAP   = 2'b10;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rbeat_t;

   logic        clk = 1'b0;
   logic        arst;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;
   int          checks = 0;
   int          errors = 0;
   string       cur_test = "init";
   rbeat_t      sb[$];

   always #5 clk = ~clk;

   axi_sram_slave #(
      .MEM_KB   (16),
      .BASE_ADDR(32'h0000_0000),
      .INIT_FILE("")
   ) dut (
      .clk     (clk),
      .arst    (arst),
      .axi_mosi(mosi),
      .axi_miso(miso)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", cur_test, tag, obs, exp);
      end
   endtask

   // AW and AR must never be granted together.
   always @(negedge clk) begin
      if (arst === 1'b1 && (miso.awready === 1'b1 || miso.arready === 1'b1))
         chk("ready_exclusive", 32'(miso.awready & miso.arready), 32'd0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic timeout_chk(input string tag, input int n);
      chk({tag, "_timeout"}, 32'(n >= 100), 32'd0);
   endtask

   task automatic expect_r(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
      rbeat_t e;
      e.data = d; e.resp = r; e.last = l; e.id = id;
      sb.push_back(e);
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      @(negedge clk);
      mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len;
      mosi.awsize = 3'd2; mosi.awburst = burst; mosi.awvalid = 1'b1;
      #1;
      while (miso.awready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      timeout_chk("aw", n);
      @(posedge clk); #1;
      mosi.awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      @(negedge clk);
      mosi.arid = id; mosi.araddr = addr; mosi.arlen = len;
      mosi.arsize = 3'd2; mosi.arburst = burst; mosi.arvalid = 1'b1;
      #1;
      while (miso.arready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      timeout_chk("ar", n);
      @(posedge clk); #1;
      mosi.arvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
      int n = 0;
      @(negedge clk);
      mosi.wdata = d; mosi.wstrb = strb; mosi.wlast = last; mosi.wvalid = 1'b1;
      #1;
      while (miso.wready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      timeout_chk("w", n);
      @(posedge clk); #1;
      mosi.wvalid = 1'b0;
   endtask

   task automatic recv_b(input logic [3:0] id, input logic [1:0] resp);
      int n = 0;
      @(negedge clk);
      mosi.bready = 1'b1;
      #1;
      while (miso.bvalid !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      timeout_chk("b", n);
      chk("bid", 32'(miso.bid), 32'(id));
      chk("bresp", 32'(miso.bresp), 32'(resp));
      @(posedge clk); #1;
      mosi.bready = 1'b0;
   endtask

   // Accepts nbeats R beats; toggle drives rready 1,0,0,1,0,0,... and checks hold stability.
   task automatic collect_r(input int nbeats, input bit toggle);
      int          got = 0;
      int          cyc = 0;
      int          lasts = 0;
      bit          held_v = 1'b0;
      logic [31:0] held_d = '0;
      logic        held_l = 1'b0;
      rbeat_t      e;
      while (got < nbeats && cyc < 200) begin
         @(negedge clk);
         mosi.rready = toggle ? ((cyc % 3) == 0) : 1'b1;
         #1;
         if (miso.rvalid === 1'b1) begin
            if (held_v) begin
               chk("r_hold_data", miso.rdata, held_d);
               chk("r_hold_last", 32'(miso.rlast), 32'(held_l));
            end
            if (mosi.rready) begin
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("rdata", miso.rdata, e.data);
                  chk("rresp", 32'(miso.rresp), 32'(e.resp));
                  chk("rlast", 32'(miso.rlast), 32'(e.last));
                  chk("rid", 32'(miso.rid), 32'(e.id));
               end else begin
                  chk("r_extra_beat", 32'(sb.size()), 32'd1);
               end
               if (miso.rlast) lasts++;
               got++;
               held_v = 1'b0;
            end else begin
               held_v = 1'b1;
               held_d = miso.rdata;
               held_l = miso.rlast;
            end
         end
         cyc++;
      end
      chk("r_timeout", 32'(cyc >= 200), 32'd0);
      chk("r_last_count", 32'(lasts), 32'd1);
      @(posedge clk); #1;
      mosi.rready = 1'b0;
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                              input logic [1:0] resp);
      $display("txn write id=%0d addr=0x%08h len=%0d d0=0x%08h strb=0x%h", id, addr, len, d0, strb);
      send_aw(id, addr, len, burst);
      for (int i = 0; i <= int'(len); i++)
         send_w(d0 + 32'(i), strb, i == int'(len));
      recv_b(id, resp);
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input bit toggle);
      $display("txn read  id=%0d addr=0x%08h len=%0d burst=%0d toggle=%0d", id, addr, len, burst, toggle);
      send_ar(id, addr, len, burst);
      collect_r(int'(len) + 1, toggle);
   endtask

   initial begin
      int cnt;
      int n;

      // ---------------- reset state ----------------
      mosi = '0;
      arst = 1'b0;
      cur_test = "reset";
      mosi.awvalid = 1'b1;
      mosi.arvalid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("awready", 32'(miso.awready), 32'd0);
      chk("arready", 32'(miso.arready), 32'd0);
      chk("wready", 32'(miso.wready), 32'd0);
      chk("bvalid", 32'(miso.bvalid), 32'd0);
      chk("rvalid", 32'(miso.rvalid), 32'd0);
      chk("rlast", 32'(miso.rlast), 32'd0);
      chk("bid", 32'(miso.bid), 32'd0);
      chk("rdata", miso.rdata, 32'd0);
      mosi.awvalid = 1'b0;
      mosi.arvalid = 1'b0;
      @(negedge clk);
      arst = 1'b1;

      // ---------------- round-robin arbitration ----------------
      cur_test = "rr";
      @(negedge clk);
      mosi.awid = 4'd1; mosi.awaddr = 32'h40; mosi.awlen = 8'd0; mosi.awsize = 3'd2; mosi.awburst = INCR;
      mosi.arid = 4'd2; mosi.araddr = 32'h40; mosi.arlen = 8'd0; mosi.arsize = 3'd2; mosi.arburst = INCR;
      mosi.awvalid = 1'b1;
      mosi.arvalid = 1'b1;
      #1;
      chk("first_awready", 32'(miso.awready), 32'd1);
      chk("first_arready", 32'(miso.arready), 32'd0);
      @(posedge clk); #1;
      mosi.awid = 4'd3; mosi.awaddr = 32'h44;          // second write stays pending
      send_w(32'hC0, 4'hF, 1'b1);
      recv_b(4'd1, OKAY);
      @(negedge clk); #1;
      chk("second_arready", 32'(miso.arready), 32'd1);
      chk("second_awready", 32'(miso.awready), 32'd0);
      expect_r(32'hC0, OKAY, 1'b1, 4'd2);
      @(posedge clk); #1;
      mosi.arid = 4'd4; mosi.araddr = 32'h44;          // keep AR contending
      collect_r(1, 1'b0);
      @(negedge clk); #1;
      chk("third_awready", 32'(miso.awready), 32'd1);
      chk("third_arready", 32'(miso.arready), 32'd0);
      @(posedge clk); #1;
      mosi.awvalid = 1'b0;
      send_w(32'hC1, 4'hF, 1'b1);
      recv_b(4'd3, OKAY);
      @(negedge clk); #1;
      chk("fourth_arready", 32'(miso.arready), 32'd1);
      expect_r(32'hC1, OKAY, 1'b1, 4'd4);
      @(posedge clk); #1;
      mosi.arvalid = 1'b0;
      collect_r(1, 1'b0);

      // ---------------- INCR write / read back ----------------
      cur_test = "incr";
      write_burst(4'd3, 32'h10, 8'd3, INCR, 32'hA0, 4'hF, OKAY);
      for (int i = 0; i < 4; i++) expect_r(32'hA0 + 32'(i), OKAY, i == 3, 4'd5);
      read_burst(4'd5, 32'h10, 8'd3, INCR, 1'b0);

      // ---------------- WRAP read ----------------
      cur_test = "wrap";
      write_burst(4'd6, 32'h0, 8'd3, INCR, 32'h0, 4'hF, OKAY);
      expect_r(32'd2, OKAY, 1'b0, 4'd7);
      expect_r(32'd3, OKAY, 1'b0, 4'd7);
      expect_r(32'd0, OKAY, 1'b0, 4'd7);
      expect_r(32'd1, OKAY, 1'b1, 4'd7);
      read_burst(4'd7, 32'h08, 8'd3, WRAP, 1'b0);

      // ---------------- byte strobes ----------------
      cur_test = "strb";
      write_burst(4'd1, 32'h20, 8'd0, INCR, 32'hFFFF_FFFF, 4'hF, OKAY);
      write_burst(4'd1, 32'h20, 8'd0, INCR, 32'h1234_5678, 4'h3, OKAY);
      expect_r(32'hFFFF_5678, OKAY, 1'b1, 4'd8);
      read_burst(4'd8, 32'h20, 8'd0, INCR, 1'b0);

      // ---------------- rready backpressure ----------------
      cur_test = "stall";
      write_burst(4'd2, 32'h100, 8'd7, INCR, 32'hB0, 4'hF, OKAY);
      for (int i = 0; i < 8; i++) expect_r(32'hB0 + 32'(i), OKAY, i == 7, 4'd9);
      read_burst(4'd9, 32'h100, 8'd7, INCR, 1'b1);

      // ---------------- reset in the middle of a read ----------------
      cur_test = "rst_mid";
      send_ar(4'd10, 32'h100, 8'd7, INCR);
      mosi.rready = 1'b1;
      cnt = 0;
      n = 0;
      while (n < 50) begin
         @(negedge clk); #1;
         n++;
         if (miso.rvalid === 1'b1) begin
            chk("pre_rst_data", miso.rdata, 32'hB0 + 32'(cnt));
            if (cnt == 2) break;
            cnt++;
         end
      end
      timeout_chk("pre_rst", n * 2);
      arst = 1'b0;
      #1;
      chk("rvalid_drop", 32'(miso.rvalid), 32'd0);
      chk("rlast_drop", 32'(miso.rlast), 32'd0);
      mosi.rready = 1'b0;
      repeat (2) @(negedge clk);
      arst = 1'b1;
      for (int i = 0; i < 4; i++) expect_r(32'hA0 + 32'(i), OKAY, i == 3, 4'd11);
      read_burst(4'd11, 32'h10, 8'd3, INCR, 1'b0);

      // ---------------- top-of-array behaviour ----------------
      cur_test = "oor";
      write_burst(4'd12, 32'h0, 8'd0, INCR, 32'h5A5A_5A5A, 4'hF, OKAY);
      write_burst(4'd12, 32'h3FFC, 8'd0, INCR, 32'hD00D_F00D, 4'hF, OKAY);
      expect_r(32'hD00D_F00D, OKAY, 1'b0, 4'd13);
`ifdef AXI_SRAM_OOR_SLVERR_EN
      expect_r(32'h0, SLVERR, 1'b1, 4'd13);
`else
      expect_r(32'h5A5A_5A5A, OKAY, 1'b1, 4'd13);   // wraps onto word 0
`endif
      read_burst(4'd13, 32'h3FFC, 8'd1, INCR, 1'b0);
`ifdef AXI_SRAM_OOR_SLVERR_EN
      write_burst(4'd14, 32'h3FFC, 8'd1, INCR, 32'hE0, 4'hF, SLVERR);
      expect_r(32'h5A5A_5A5A, OKAY, 1'b1, 4'd15);    // suppressed beat left word 0 alone
`else
      write_burst(4'd14, 32'h3FFC, 8'd1, INCR, 32'hE0, 4'hF, OKAY);
      expect_r(32'hE1, OKAY, 1'b1, 4'd15);           // second beat wrapped onto word 0
`endif
      read_burst(4'd15, 32'h0, 8'd0, INCR, 1'b0);

      cur_test = "end";
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
